// File: rtl/conv_result_streamer.sv
// conv_result_streamer
// Captures a row of N_RESULTS signed 18-bit conv results on a done_in pulse,
// then streams them one beat at a time over a valid/ready interface.
// Each beat is requantized by an arithmetic right shift of SHIFT bits and
// saturated to a signed 8-bit range.
// Optional feature: define RESULT_RELU_EN to clamp negative results to 0,
// which gives an output range of [0,127] instead of [-128,127].
// A done_in that arrives mid-row is dropped and reported on overrun.
// A done_in that coincides with the final beat's transfer starts the next
// row back-to-back.

module conv_result_streamer #(
  parameter int N_RESULTS = 30,  // results per row, 2..32
  parameter int SHIFT     = 2    // requantization right shift, 0..10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_in,
  input  logic signed [17:0] result_in [N_RESULTS],
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [7:0]  out_data,
  output logic [4:0]         out_index,
  output logic               out_last,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [4:0]         LAST_INDEX = 5'(N_RESULTS - 1);
  localparam logic signed [17:0] SAT_MAX    = 18'sd127;
  localparam logic signed [17:0] SAT_MIN    = -18'sd128;

  state_t             state;
  state_t             state_next;
  logic signed [17:0] buffer [N_RESULTS];
  logic [4:0]         index;
  logic               transfer;
  logic               final_transfer;
  logic               capture;
  logic               drop;
  logic signed [17:0] current;
  logic signed [17:0] shifted;
  logic signed [7:0]  requant;

  // Handshake qualifiers shared by the state, index and buffer logic.
  always_comb begin
    transfer       = (state == STREAM) && out_ready;
    final_transfer = transfer && (index == LAST_INDEX);
    capture        = done_in && ((state == IDLE) || final_transfer);
    drop           = done_in && (state == STREAM) && !final_transfer;
  end

  // State register; reset wins over any done_in in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of block ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a row starts on done_in and ends on its final transfer
  // unless a new row is captured in that same cycle.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would infer a latch.
    state_next = state;
    case (state)
      IDLE: begin
        if (done_in) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (final_transfer && !done_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat index: cleared on capture and at row end, advanced on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
    end else if (capture || final_transfer) begin
      index <= '0;
    end else if (transfer) begin
      index <= index + 5'd1;
    end
  end

  // Row buffer: loaded only on a capture, otherwise held through the row.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately cleared on reset so no stale row can
    // leak out after an aborted stream; this costs a reset on every element.
    if (rst) begin
      for (int i = 0; i < N_RESULTS; i++) begin
        buffer[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < N_RESULTS; i++) begin
        buffer[i] <= result_in[i];
      end
    end
  end

  // Overrun flag: one-cycle pulse the cycle after a dropped done_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= drop;
    end
  end

  // Requantization of the current element: floor shift, then clamp.
  always_comb begin
    current = buffer[index];
    shifted = current >>> SHIFT;
    requant = shifted[7:0];
`ifdef RESULT_RELU_EN
    if (shifted < 18'sd0) begin
      requant = 8'sd0;
    end else if (shifted > SAT_MAX) begin
      requant = 8'sd127;
    end
`else
    if (shifted > SAT_MAX) begin
      requant = 8'sd127;
    end else if (shifted < SAT_MIN) begin
      requant = -8'sd128;
    end
`endif
  end

  // Output decode: beat fields are driven only while streaming, else zero.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    case (state)
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = requant;
        out_index = index;
        out_last  = (index == LAST_INDEX);
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/conv_result_streamer.md
CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

Interface
REQ-001 Parameter N_RESULTS, default 30, is the number of conv results per row; valid range 2..32.
REQ-002 Parameter SHIFT, default 2, is the requantization right-shift amount; valid range 0..10.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 done_in  input  1  one-cycle pulse; result_in is valid in that cycle.
REQ-006 result_in  input  N_RESULTS x signed 18  unpacked array of conv results, element 0 first.
REQ-007 out_valid  output  1  stream beat valid.
REQ-008 out_ready  input  1  downstream accepts beat.
REQ-009 out_data  output  signed 8  requantized result.
REQ-010 out_index  output  5  index of the current beat, 0..N_RESULTS-1.
REQ-011 out_last  output  1  high on the beat with out_index = N_RESULTS-1.
REQ-012 busy  output  1  high while in STREAM.
REQ-013 overrun  output  1  one-cycle pulse when a done_in is dropped.

Function
REQ-014 The state machine SHALL have two states, IDLE and STREAM.
REQ-015 In IDLE, done_in=1 SHALL capture all result_in elements into an internal buffer, clear the index to 0 and enter STREAM.
REQ-016 out_valid and busy SHALL be high in the cycle after capture (latency 1); element 0 is presented first.
REQ-017 A transfer SHALL occur only in a cycle where out_valid=1 and out_ready=1.
REQ-018 On a transfer, the index SHALL increment by 1.
REQ-019 On the transfer with index N_RESULTS-1, the block SHALL return to IDLE and drop out_valid in the next cycle.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-021 out_data SHALL be buffer[index] arithmetic-shifted right by SHIFT (floor toward negative infinity), then saturated to [-128,127].
REQ-022 out_data, out_index and out_last SHALL be 0 whenever out_valid=0.
REQ-023 done_in=1 in STREAM, other than in the final-transfer cycle, SHALL be ignored: buffer and stream are unchanged and overrun pulses high for one cycle in the next cycle.
REQ-024 done_in=1 in the same cycle as the final transfer SHALL capture the new row and stay in STREAM with index 0.
  - out_valid stays high without a gap.
  - overrun is not asserted.
REQ-025 out_ready SHALL be ignored in IDLE; it creates no transfer and no state change.

Reset
REQ-026 rst=1 SHALL force, at the next edge:
  - state IDLE, index 0 and buffer all 0;
  - out_valid, out_data, out_index, out_last, busy and overrun all 0.
REQ-027 rst asserted mid-stream SHALL abort the row.
  - No further beats are produced.
  - out_last is not emitted.
  - A done_in in the same cycle as rst is discarded.

Configuration
REQ-028 Macro RESULT_RELU_EN selects the clamping range.
  - Defined: any negative shifted value is output as 0, so the out_data range is [0,127].
  - Not defined: the signed range [-128,127] of REQ-021 applies.

Verification
REQ-029 SHIFT=2, out_ready=1, result_in = {300, 1000, -3, -1000, 0, ...}, pulse done_in -> beats 75, 127, -1, -128, 0, ...; 30 beats on consecutive cycles; out_last only at index 29.
REQ-030 Same stimulus with RESULT_RELU_EN defined -> beats 75, 127, 0, 0, 0, ...
REQ-031 Hold out_ready=0 for 5 cycles at index 3 -> out_data, out_index and out_last are unchanged for those cycles; the stream resumes at index 3 with no loss or duplication.
REQ-032 Pulse done_in at index 10 -> overrun pulses once and the original stream completes unchanged; pulse done_in together with the index-29 transfer -> the second row starts immediately, out_valid has no gap, no overrun.
REQ-033 Assert rst at index 15 -> the next cycle has out_valid=0, busy=0 and all outputs 0; a later done_in produces a full 30-beat row starting at index 0.
